nios_128k_base_key_pio: RTL

Avalon-MM slave input port for the nios_128k_base system, mirroring the output PIO that drives the hex displays: it samples an external WIDTH-bit input bus (push-buttons and switches), synchronises it to clk, latches edges per bit into an edge-capture register and raises a level-sensitive interrupt to the Nios II when any enabled captured bit is set. Software reads the live value, programs an interrupt mask and clears captured edges through four word-addressed registers.

---
 rtl/nios_128k_base_key_pio_if.sv | 26 ++
 rtl/nios_128k_base_key_pio.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/nios_128k_base_key_pio_if.sv
// Avalon-MM slave bus bundle for the key/switch input PIO.
// Word-addressed, single-cycle writes, registered reads (latency 1).
// No wait states: the slave never stalls the master.
interface nios_128k_base_key_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/nios_128k_base_key_pio.sv
// Input PIO: samples push-buttons/switches, captures edges per bit, level irq.
// Read latency 1 clk; in_port -> EDGECAP 1 clk (3 clk with NIOS_KEY_PIO_SYNC_EN).
// No backpressure: always ready; optional 2-flop sync via NIOS_KEY_PIO_SYNC_EN.
module nios_128k_base_key_pio #(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  nios_128k_base_key_pio_if.slave bus,
  input  logic [WIDTH-1:0]       in_port,
  output logic                   irq
);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  // Synchronised view of the pins; everything downstream sees only s.
  logic [WIDTH-1:0] s;

`ifdef NIOS_KEY_PIO_SYNC_EN
  // The sync stages hold their reset zeros for two clocks, so arming waits
  // until s reflects the real pins; otherwise keys held high through reset
  // would look like a rising edge.
  localparam logic [1:0] PRIME_LAST = 2'd2;

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;

  // Two-stage synchroniser next-state.
  always_comb begin
    s1_d = in_port;
    s2_d = s1_q;
  end

  // Synchroniser flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign s = s2_q;
`else
  // Pins are already synchronous to clk; arm on the first clock.
  localparam logic [1:0] PRIME_LAST = 2'd0;

  assign s = in_port;
`endif

  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [1:0]       prime_cnt_q, prime_cnt_d;
  logic             armed_q, armed_d;

  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] edge_raw;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr;
  logic [31:0]      data_ext;
  logic [31:0]      mask_ext;
  logic [31:0]      edgecap_ext;

  // Upper writedata bits beyond WIDTH carry no meaning for this block.
  logic unused_wdata;
  assign unused_wdata = ^bus.writedata;

  // Bus decode, edge detection, capture/clear and read mux.
  always_comb begin
    wr_en = bus.chipselect & ~bus.write_n;
    rd_en = bus.chipselect &  bus.write_n;

    // Edge polarity is fixed at elaboration; unknown values fall back to rising.
    edge_raw = s & ~p_q;
    if (EDGE_TYPE == 1) begin
      edge_raw = ~s & p_q;
    end else if (EDGE_TYPE == 2) begin
      edge_raw = s ^ p_q;
    end

    // Until armed, p is just tracking s and any apparent edge is reset debris.
    edge_det = armed_q ? edge_raw : '0;
    p_d      = s;

    prime_cnt_d = (prime_cnt_q == PRIME_LAST) ? prime_cnt_q : prime_cnt_q + 2'd1;
    armed_d     = armed_q | (prime_cnt_q == PRIME_LAST);

    // Write-1-to-clear; a fresh edge in the same cycle wins over the clear.
    clr = '0;
    if (wr_en && bus.address == ADDR_EDGECAP) begin
      clr = bus.writedata[WIDTH-1:0];
    end
    edgecap_d = edge_det | (edgecap_q & ~clr);

    mask_d = mask_q;
    if (wr_en && bus.address == ADDR_IRQMASK) begin
      mask_d = bus.writedata[WIDTH-1:0];
    end

    data_ext                 = '0;
    data_ext[WIDTH-1:0]      = s;
    mask_ext                 = '0;
    mask_ext[WIDTH-1:0]      = mask_q;
    edgecap_ext              = '0;
    edgecap_ext[WIDTH-1:0]   = edgecap_q;

    // Reads are side-effect free and show register state before this edge.
    readdata_d = readdata_q;
    if (rd_en) begin
      case (bus.address)
        ADDR_DATA:    readdata_d = data_ext;
        ADDR_RSVD:    readdata_d = '0;
        ADDR_IRQMASK: readdata_d = mask_ext;
        ADDR_EDGECAP: readdata_d = edgecap_ext;
        default:      readdata_d = '0;
      endcase
    end
  end

  // Register state; reset clears everything so priming restarts on release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_q         <= '0;
      edgecap_q   <= '0;
      mask_q      <= '0;
      readdata_q  <= '0;
      prime_cnt_q <= '0;
      armed_q     <= 1'b0;
    end else begin
      p_q         <= p_d;
      edgecap_q   <= edgecap_d;
      mask_q      <= mask_d;
      readdata_q  <= readdata_d;
      prime_cnt_q <= prime_cnt_d;
      armed_q     <= armed_d;
    end
  end

  assign bus.readdata = readdata_q;

  // Level interrupt straight from flops, so no combinational glitch source.
  assign irq = |(edgecap_q & mask_q);

endmodule
